multdiv_ctrl: RTL and testbench
===============================

Name: multdiv_ctrl

Overview:
- Sequencing controller upstream of the multdiv cycle counter.
- Accepts a mult/div request from decode and latches operands and destination register.
- Issues a one-cycle start pulse to the counter/datapath, stalls the pipeline until the counter's ready arrives, then emits a single writeback beat.
- Sits between the decode/execute stage and the regfile writeback mux.

Parameters:
- WIDTH, 32, operand/result width
- RD_W, 5, destination register index width
- TIMEOUT, 40, max WAIT cycles before abort (used only with MD_TIMEOUT_EN)

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- req_mult  in  1  decode requests multiply this cycle
- req_div  in  1  decode requests divide this cycle
- op_a  in  WIDTH  operand A
- op_b  in  WIDTH  operand B
- req_rd  in  RD_W  destination register
- flush  in  1  squash any in-flight or incoming op
- ready_in  in  1  counter ready
- result_in  in  WIDTH  datapath result
- exception_in  in  1  datapath overflow / divide-by-zero
- start  out  1  one-cycle start pulse to counter and datapath
- md_a  out  WIDTH  latched operand A
- md_b  out  WIDTH  latched operand B
- md_op  out  1  latched op: 0 = mult, 1 = div
- stall  out  1  freeze upstream pipeline
- wb_valid  out  1  writeback beat
- wb_rd  out  RD_W  writeback register
- wb_data  out  WIDTH  writeback data

Behaviour:
- Reset (asynchronous, active-high): state IDLE; all outputs and internal registers 0.
- States: IDLE, LAUNCH, WAIT, WRITE.
- Request acceptance (in IDLE or WRITE): a request is accepted when (req_mult|req_div) & ~flush.
  - On acceptance, latch op_a, op_b, req_rd and md_op (req_div & ~req_mult; mult wins if both are high).
  - Next state is LAUNCH.
- Stall: combinational. stall = accepted-request-this-cycle | LAUNCH | WAIT. stall is 0 in WRITE unless a new request is accepted.
- LAUNCH: start=1 for exactly this cycle; next state WAIT. ready_in is ignored here because the counter value is stale.
- WAIT: hold md_a, md_b and md_op stable. On the first cycle with ready_in=1, register result_in and exception_in, then go to WRITE. Otherwise stay in WAIT.
- WRITE: wb_valid=1 for one cycle; then IDLE, or LAUNCH if a request is accepted this cycle (back-to-back).
  - No exception: wb_rd = latched rd, wb_data = captured result.
  - Exception: wb_rd = 30, wb_data = 4 (mult) or 5 (div).
  - Latched rd == 0 and no exception: wb_valid stays 0; the state still passes through WRITE.
- Outside WRITE, wb_valid=0. wb_rd and wb_data hold their last values.
- flush: has priority in every state. Next state is IDLE, with no start, no writeback, and stall=0 that cycle. A flush in LAUNCH suppresses start.
- Latency: accept at cycle T, start at T+1. The counter raises ready 33 cycles after start, at T+34; wb_valid follows at T+35.
- ready_in while in IDLE or WRITE: ignored.

Optional Feature:
- Macro: MD_TIMEOUT_EN.
- Defined:
  - A 6-bit WAIT counter clears on entry to WAIT.
  - If it reaches TIMEOUT with no ready_in, go to WRITE with the exception path forced (wb_rd=30, code 4 or 5).
  - ready_in arriving on the same cycle the count reaches TIMEOUT wins, and the result is written normally.
- Undefined: no counter; WAIT persists indefinitely until ready_in or flush.

Test Plan:
- Reset mid-WAIT → all outputs 0 immediately (asynchronously), state IDLE; the next req_mult is accepted normally.
- req_mult, a=6, b=7, rd=3 at cycle T, counter model gives ready at T+34 with result 42 → start only at T+1; stall=1 from T through T+34; wb_valid at T+35 with rd=3, data=42.
- req_div with exception_in=1 at ready → wb_rd=30, wb_data=5. The mult variant gives wb_data=4.
- Second req_div presented in the WRITE cycle → first op's wb_valid=1 that cycle, start on the next cycle, stall held continuously.
- flush asserted in LAUNCH and in WAIT, and flush together with a req in IDLE → no start, no wb_valid, stall=0 that cycle, IDLE next cycle.
- MD_TIMEOUT_EN defined, TIMEOUT=40, ready_in never asserted on a mult → wb_valid 40 WAIT cycles after entry, wb_rd=30, wb_data=4.

Source files
------------

// File: rtl/multdiv_ctrl_if.sv
// multdiv_ctrl_if: request, launch and writeback signals of the
// multiply/divide sequencing controller.
//   master : decode/execute side plus counter/datapath responses
//   slave  : the controller itself
interface multdiv_ctrl_if #(
    parameter int WIDTH = 32,
    parameter int RD_W  = 5
);
    logic             req_mult;
    logic             req_div;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [RD_W-1:0]  req_rd;
    logic             flush;
    logic             ready_in;
    logic [WIDTH-1:0] result_in;
    logic             exception_in;
    logic             start;
    logic [WIDTH-1:0] md_a;
    logic [WIDTH-1:0] md_b;
    logic             md_op;
    logic             stall;
    logic             wb_valid;
    logic [RD_W-1:0]  wb_rd;
    logic [WIDTH-1:0] wb_data;

    modport master (
        output req_mult, req_div, op_a, op_b, req_rd, flush,
               ready_in, result_in, exception_in,
        input  start, md_a, md_b, md_op, stall, wb_valid, wb_rd, wb_data
    );

    modport slave (
        input  req_mult, req_div, op_a, op_b, req_rd, flush,
               ready_in, result_in, exception_in,
        output start, md_a, md_b, md_op, stall, wb_valid, wb_rd, wb_data
    );
endinterface

// File: rtl/multdiv_ctrl.sv
// multdiv_ctrl: sequences one multiply/divide op at a time.
// Latches operands on acceptance, pulses start for one cycle, stalls the
// pipeline until the counter reports ready, then emits one writeback beat.
// Optional feature macro: MD_TIMEOUT_EN -- a 6-bit WAIT counter forces the
// exception writeback after TIMEOUT WAIT cycles without ready_in.
module multdiv_ctrl #(
    parameter int WIDTH   = 32,
    parameter int RD_W    = 5,
    parameter int TIMEOUT = 40
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_ctrl_if.slave bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_WRITE  = 2'd3
    } state_t;

    // Exception writebacks go to x30 with a code identifying the op kind.
    localparam logic [RD_W-1:0] EXC_RD = RD_W'(32'd30);

    // The wait counter is 6 bits wide, so TIMEOUT has to fit in it.
    if (TIMEOUT < 1 || TIMEOUT > 63) begin : g_bad_timeout
        $error("multdiv_ctrl: TIMEOUT must be in 1..63");
    end

    // Exception code: 4 for multiply, 5 for divide.
    function automatic logic [WIDTH-1:0] exc_code(input logic op_div);
        logic [WIDTH-1:0] code;
        if (op_div) begin
            code = WIDTH'(32'd5);
        end else begin
            code = WIDTH'(32'd4);
        end
        return code;
    endfunction

    state_t           state_r;
    state_t           state_nxt_s;
    logic [WIDTH-1:0] md_a_r;
    logic [WIDTH-1:0] md_b_r;
    logic             md_op_r;
    logic [RD_W-1:0]  rd_r;
    logic             exc_r;
    logic [RD_W-1:0]  wb_rd_r;
    logic [WIDTH-1:0] wb_data_r;

    logic             req_any_s;
    logic             accept_s;
    logic             start_s;
    logic             stall_s;
    logic             wb_valid_s;
    logic             capture_s;

`ifdef MD_TIMEOUT_EN
    localparam logic [5:0] TIMEOUT_LAST = 6'(TIMEOUT - 1);
    logic [5:0]       wait_cnt_r;
    logic             timeout_s;
`endif

    assign req_any_s = bus.req_mult | bus.req_div;

    // Next-state and control decode; flush overrides every state.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        start_s     = 1'b0;
        stall_s     = 1'b0;
        wb_valid_s  = 1'b0;
        capture_s   = 1'b0;
`ifdef MD_TIMEOUT_EN
        timeout_s   = 1'b0;
`endif
        if (bus.flush) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_any_s) begin
                        accept_s    = 1'b1;
                        stall_s     = 1'b1;
                        state_nxt_s = ST_LAUNCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_LAUNCH: begin
                    // Counter value is stale here, so ready_in is not looked at.
                    start_s     = 1'b1;
                    stall_s     = 1'b1;
                    state_nxt_s = ST_WAIT;
                end
                ST_WAIT: begin
                    stall_s = 1'b1;
                    if (bus.ready_in) begin
                        capture_s   = 1'b1;
                        state_nxt_s = ST_WRITE;
                    end
`ifdef MD_TIMEOUT_EN
                    else if (wait_cnt_r == TIMEOUT_LAST) begin
                        timeout_s   = 1'b1;
                        state_nxt_s = ST_WRITE;
                    end
`endif
                    else begin
                        state_nxt_s = ST_WAIT;
                    end
                end
                ST_WRITE: begin
                    // A write to x0 without an exception is dropped silently.
                    wb_valid_s = exc_r | (rd_r != '0);
                    if (req_any_s) begin
                        accept_s    = 1'b1;
                        stall_s     = 1'b1;
                        state_nxt_s = ST_LAUNCH;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Operand latch on acceptance and result/exception capture for writeback.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            md_a_r    <= '0;
            md_b_r    <= '0;
            md_op_r   <= 1'b0;
            rd_r      <= '0;
            exc_r     <= 1'b0;
            wb_rd_r   <= '0;
            wb_data_r <= '0;
        end else begin
            if (accept_s) begin
                md_a_r  <= bus.op_a;
                md_b_r  <= bus.op_b;
                md_op_r <= bus.req_div & ~bus.req_mult;
                rd_r    <= bus.req_rd;
            end
            if (capture_s) begin
                exc_r <= bus.exception_in;
                if (bus.exception_in) begin
                    wb_rd_r   <= EXC_RD;
                    wb_data_r <= exc_code(md_op_r);
                end else begin
                    wb_rd_r   <= rd_r;
                    wb_data_r <= bus.result_in;
                end
            end
`ifdef MD_TIMEOUT_EN
            if (timeout_s) begin
                exc_r     <= 1'b1;
                wb_rd_r   <= EXC_RD;
                wb_data_r <= exc_code(md_op_r);
            end
`endif
        end
    end

`ifdef MD_TIMEOUT_EN
    // WAIT cycle counter; held at zero outside WAIT so it restarts on entry.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= 6'd0;
        end else if (state_r != ST_WAIT) begin
            wait_cnt_r <= 6'd0;
        end else begin
            wait_cnt_r <= wait_cnt_r + 6'd1;
        end
    end
`endif

    assign bus.start    = start_s;
    assign bus.stall    = stall_s;
    assign bus.wb_valid = wb_valid_s;
    assign bus.md_a     = md_a_r;
    assign bus.md_b     = md_b_r;
    assign bus.md_op    = md_op_r;
    assign bus.wb_rd    = wb_rd_r;
    assign bus.wb_data  = wb_data_r;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// tb_multdiv_ctrl: directed checks of the multiply/divide sequencing controller.
module tb_multdiv_ctrl;

    logic clock;
    logic reset;
    int   n_total;
    int   n_pass;

    multdiv_ctrl_if #(.WIDTH(32), .RD_W(5)) bus ();

    multdiv_ctrl #(.WIDTH(32), .RD_W(5), .TIMEOUT(40)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        assert (got === exp) n_pass++;
        else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Move to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Accept one request, end settled in the LAUNCH cycle.
    task automatic launch(input logic m, input logic d, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] rd);
        tick();
        bus.req_mult = m; bus.req_div = d;
        bus.op_a = a; bus.op_b = b; bus.req_rd = rd;
        #2;
        tick();
        bus.req_mult = 1'b0; bus.req_div = 1'b0;
        #2;
    endtask

    // From LAUNCH: spend waitc+1 WAIT cycles, raise ready in the last one,
    // end settled in the WRITE cycle.
    task automatic complete(input logic [31:0] res, input logic exc, input int waitc);
        repeat (waitc) tick();
        tick();
        bus.ready_in = 1'b1; bus.result_in = res; bus.exception_in = exc;
        #2;
        tick();
        bus.ready_in = 1'b0; bus.exception_in = 1'b0;
        #2;
    endtask

    initial begin
        n_total = 0;
        n_pass  = 0;
        bus.req_mult = 1'b0; bus.req_div = 1'b0;
        bus.op_a = 32'd0; bus.op_b = 32'd0; bus.req_rd = 5'd0;
        bus.flush = 1'b0; bus.ready_in = 1'b0;
        bus.result_in = 32'd0; bus.exception_in = 1'b0;
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        chk("rst_start", 32'(bus.start), 32'd0);
        chk("rst_stall", 32'(bus.stall), 32'd0);
        chk("rst_wb_valid", 32'(bus.wb_valid), 32'd0);
        chk("rst_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("rst_wb_data", bus.wb_data, 32'd0);
        chk("rst_md_a", bus.md_a, 32'd0);
        chk("rst_md_op", 32'(bus.md_op), 32'd0);
        reset = 1'b0;

        // Basic multiply 6*7 -> x3, full 35-cycle latency.
        tick();
        bus.req_mult = 1'b1; bus.op_a = 32'd6; bus.op_b = 32'd7; bus.req_rd = 5'd3;
        #2;
        chk("t1_T_stall", 32'(bus.stall), 32'd1);
        chk("t1_T_start", 32'(bus.start), 32'd0);
        tick();
        bus.req_mult = 1'b0;
        #2;
        chk("t1_T1_start", 32'(bus.start), 32'd1);
        chk("t1_T1_stall", 32'(bus.stall), 32'd1);
        chk("t1_md_a", bus.md_a, 32'd6);
        chk("t1_md_b", bus.md_b, 32'd7);
        chk("t1_md_op", 32'(bus.md_op), 32'd0);
        for (int i = 2; i <= 33; i++) begin
            tick();
            #2;
            chk("t1_wait_start", 32'(bus.start), 32'd0);
            chk("t1_wait_stall", 32'(bus.stall), 32'd1);
            chk("t1_wait_wbv", 32'(bus.wb_valid), 32'd0);
        end
        tick();
        bus.ready_in = 1'b1; bus.result_in = 32'd42;
        #2;
        chk("t1_T34_stall", 32'(bus.stall), 32'd1);
        chk("t1_T34_wbv", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.ready_in = 1'b0;
        #2;
        chk("t1_T35_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t1_T35_rd", 32'(bus.wb_rd), 32'd3);
        chk("t1_T35_data", bus.wb_data, 32'd42);
        chk("t1_T35_stall", 32'(bus.stall), 32'd0);
        chk("t1_T35_start", 32'(bus.start), 32'd0);
        tick();
        #2;
        chk("t1_idle_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t1_idle_hold", bus.wb_data, 32'd42);

        // Divide with exception -> x30, code 5.
        launch(1'b0, 1'b1, 32'd20, 32'd0, 5'd9);
        chk("t2_md_op", 32'(bus.md_op), 32'd1);
        complete(32'd0, 1'b1, 3);
        chk("t2_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t2_rd", 32'(bus.wb_rd), 32'd30);
        chk("t2_data", bus.wb_data, 32'd5);

        // Multiply with exception -> x30, code 4.
        launch(1'b1, 1'b0, 32'd3, 32'd4, 5'd2);
        complete(32'd123, 1'b1, 3);
        chk("t3_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t3_rd", 32'(bus.wb_rd), 32'd30);
        chk("t3_data", bus.wb_data, 32'd4);

        // Back-to-back: new divide accepted in the WRITE cycle.
        launch(1'b0, 1'b1, 32'd100, 32'd7, 5'd4);
        complete(32'd14, 1'b0, 2);
        bus.req_div = 1'b1; bus.op_a = 32'd50; bus.op_b = 32'd5; bus.req_rd = 5'd6;
        #2;
        chk("t4_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t4_rd", 32'(bus.wb_rd), 32'd4);
        chk("t4_data", bus.wb_data, 32'd14);
        chk("t4_wr_stall", 32'(bus.stall), 32'd1);
        chk("t4_wr_start", 32'(bus.start), 32'd0);
        tick();
        bus.req_div = 1'b0;
        #2;
        chk("t4_l_start", 32'(bus.start), 32'd1);
        chk("t4_l_stall", 32'(bus.stall), 32'd1);
        chk("t4_l_md_a", bus.md_a, 32'd50);
        chk("t4_l_md_op", 32'(bus.md_op), 32'd1);
        chk("t4_l_wbv", 32'(bus.wb_valid), 32'd0);
        complete(32'd10, 1'b0, 1);
        chk("t4b_rd", 32'(bus.wb_rd), 32'd6);
        chk("t4b_data", bus.wb_data, 32'd10);

        // Flush in LAUNCH suppresses start.
        tick();
        bus.req_mult = 1'b1; bus.op_a = 32'd1; bus.op_b = 32'd2; bus.req_rd = 5'd7;
        #2;
        tick();
        bus.req_mult = 1'b0; bus.flush = 1'b1;
        #2;
        chk("t5_fl_start", 32'(bus.start), 32'd0);
        chk("t5_fl_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush = 1'b0;
        #2;
        chk("t5_idle_stall", 32'(bus.stall), 32'd0);
        chk("t5_idle_start", 32'(bus.start), 32'd0);

        // Flush in WAIT beats a simultaneous ready.
        launch(1'b1, 1'b0, 32'd3, 32'd4, 5'd8);
        tick();
        tick();
        bus.flush = 1'b1; bus.ready_in = 1'b1; bus.result_in = 32'd55;
        #2;
        chk("t6_fl_stall", 32'(bus.stall), 32'd0);
        chk("t6_fl_wbv", 32'(bus.wb_valid), 32'd0);
        tick();
        bus.flush = 1'b0; bus.ready_in = 1'b0;
        #2;
        chk("t6_next_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t6_next_stall", 32'(bus.stall), 32'd0);
        chk("t6_hold_data", bus.wb_data, 32'd10);

        // Flush together with a request in IDLE.
        tick();
        bus.req_mult = 1'b1; bus.flush = 1'b1;
        #2;
        chk("t7_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.req_mult = 1'b0; bus.flush = 1'b0;
        #2;
        chk("t7_start", 32'(bus.start), 32'd0);
        chk("t7_stall_next", 32'(bus.stall), 32'd0);

        // Destination x0 without exception: no writeback beat.
        launch(1'b1, 1'b0, 32'd2, 32'd3, 5'd0);
        complete(32'd6, 1'b0, 1);
        chk("t8_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t8_stall", 32'(bus.stall), 32'd0);

        // ready_in in IDLE is ignored.
        tick();
        bus.ready_in = 1'b1; bus.result_in = 32'd99;
        #2;
        chk("t9_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.ready_in = 1'b0;
        #2;
        chk("t9_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t9_start", 32'(bus.start), 32'd0);

        // Both requests: mult wins; ready in LAUNCH is ignored.
        tick();
        bus.req_mult = 1'b1; bus.req_div = 1'b1;
        bus.op_a = 32'd9; bus.op_b = 32'd9; bus.req_rd = 5'd5;
        #2;
        tick();
        bus.req_mult = 1'b0; bus.req_div = 1'b0;
        bus.ready_in = 1'b1; bus.result_in = 32'd99;
        #2;
        chk("t10_start", 32'(bus.start), 32'd1);
        chk("t10_md_op", 32'(bus.md_op), 32'd0);
        tick();
        bus.ready_in = 1'b0;
        #2;
        chk("t10_wait_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t10_wait_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.ready_in = 1'b1; bus.result_in = 32'd77;
        #2;
        tick();
        bus.ready_in = 1'b0;
        #2;
        chk("t10_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t10_rd", 32'(bus.wb_rd), 32'd5);
        chk("t10_data", bus.wb_data, 32'd77);

        // No ready at all on a multiply.
        launch(1'b1, 1'b0, 32'd11, 32'd12, 5'd13);
`ifdef MD_TIMEOUT_EN
        for (int k = 0; k < 40; k++) begin
            tick();
            #2;
            chk("t11_wait_stall", 32'(bus.stall), 32'd1);
            chk("t11_wait_wbv", 32'(bus.wb_valid), 32'd0);
        end
        tick();
        #2;
        chk("t11_to_wbv", 32'(bus.wb_valid), 32'd1);
        chk("t11_to_rd", 32'(bus.wb_rd), 32'd30);
        chk("t11_to_data", bus.wb_data, 32'd4);
        chk("t11_to_stall", 32'(bus.stall), 32'd0);
`else
        for (int k = 0; k < 60; k++) begin
            tick();
            #2;
            chk("t11_wait_stall", 32'(bus.stall), 32'd1);
            chk("t11_wait_wbv", 32'(bus.wb_valid), 32'd0);
        end
        tick();
        bus.flush = 1'b1;
        #2;
        chk("t11_fl_stall", 32'(bus.stall), 32'd0);
        tick();
        bus.flush = 1'b0;
        #2;
`endif

        // Asynchronous reset in the middle of WAIT.
        launch(1'b1, 1'b0, 32'd8, 32'd9, 5'd10);
        tick();
        #2;
        reset = 1'b1;
        #1;
        chk("t12_stall", 32'(bus.stall), 32'd0);
        chk("t12_start", 32'(bus.start), 32'd0);
        chk("t12_md_a", bus.md_a, 32'd0);
        chk("t12_md_b", bus.md_b, 32'd0);
        chk("t12_wbv", 32'(bus.wb_valid), 32'd0);
        chk("t12_wb_rd", 32'(bus.wb_rd), 32'd0);
        chk("t12_wb_data", bus.wb_data, 32'd0);
        #1;
        reset = 1'b0;
        tick();
        bus.req_mult = 1'b1; bus.op_a = 32'd2; bus.op_b = 32'd3; bus.req_rd = 5'd1;
        #2;
        chk("t12_acc_stall", 32'(bus.stall), 32'd1);
        tick();
        bus.req_mult = 1'b0;
        #2;
        chk("t12_acc_start", 32'(bus.start), 32'd1);
        chk("t12_acc_md_a", bus.md_a, 32'd2);
        complete(32'd6, 1'b0, 0);
        chk("t12_wbv_after", 32'(bus.wb_valid), 32'd1);
        chk("t12_rd_after", 32'(bus.wb_rd), 32'd1);
        chk("t12_data_after", bus.wb_data, 32'd6);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
